icache_fill: RTL and testbench



---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_array.sv | 56 +++++
 rtl/icache_fill.sv | 159 +++++++++++++++
 tb/tb_icache_fill.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Geometry constants and FSM state type shared by the
// direct-mapped instruction cache and its storage array.
package icache_pkg;

    localparam int DEF_LINES = 32;
    localparam int DEF_WORDS = 8;

    localparam int OFF_W = $clog2(DEF_WORDS);
    localparam int IDX_W = $clog2(DEF_LINES);
    localparam int TAG_W = 16 - IDX_W - OFF_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one write port,
// combinational read, async-cleared valid bits with bulk invalidate.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             inv_i,
    input  logic             fill_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] w_idx_i,
    input  logic [TAG_W-1:0] w_tag_i,
    input  logic [OFF_W-1:0] w_off_i,
    input  logic [15:0]      w_data_i,
    input  logic [IDX_W-1:0] r_idx_i,
    input  logic [OFF_W-1:0] r_off_i,
    output logic             r_valid_o,
    output logic [TAG_W-1:0] r_tag_o,
    output logic [15:0]      r_data_o
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [LINES][WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (inv_i) begin
            valid_q[w_idx_i] <= 1'b0;
        end else if (fill_i) begin
            valid_q[w_idx_i] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[w_idx_i] <= w_tag_i;
        end
        if (we_i) begin
            data_q[w_idx_i][w_off_i] <= w_data_i;
        end
    end

    assign r_valid_o = valid_q[r_idx_i];
    assign r_tag_o   = tag_q[r_idx_i];
    assign r_data_o  = data_q[r_idx_i][r_off_i];

endmodule

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache: same-cycle hit lookup and a
// line-fill FSM that streams one line from pipelined main memory.
module icache_fill
    import icache_pkg::*;
#(
    parameter int LINES   = DEF_LINES,
    parameter int WORDS   = DEF_WORDS,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic [15:0] pc_addr,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic        stall,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] miss_cnt
);

    localparam logic [OFF_W:0]   ISSUE_END = (OFF_W + 1)'(WORDS);
    localparam logic [OFF_W-1:0] RET_LAST  = OFF_W'(WORDS - 1);

    if (MEM_LAT < 1 || LINES != 2 ** IDX_W || WORDS != 2 ** OFF_W) begin : g_cfg_chk
        $error("icache_fill: parameters disagree with icache_pkg geometry");
    end

    state_e           state_q, state_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic [OFF_W:0]   issue_q, issue_d;
    logic [OFF_W-1:0] ret_q, ret_d;
    logic [15:0]      miss_q, miss_d;
    logic             flush_pend_q, flush_pend_d;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc_lsb;

    assign pc_off        = pc_addr[OFF_W:1];
    assign pc_idx        = pc_addr[OFF_W+IDX_W:OFF_W+1];
    assign pc_tag        = pc_addr[15:OFF_W+IDX_W+1];
    assign unused_pc_lsb = pc_addr[0];

    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic             hit;
    logic             arr_flush, arr_inv, arr_fill, arr_we;
    logic [IDX_W-1:0] arr_idx;

    assign arr_idx = (state_q == IDLE) ? pc_idx : fill_idx_q;

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (arr_flush),
        .inv_i     (arr_inv),
        .fill_i    (arr_fill),
        .we_i      (arr_we),
        .w_idx_i   (arr_idx),
        .w_tag_i   (fill_tag_q),
        .w_off_i   (ret_q),
        .w_data_i  (mem_rdata),
        .r_idx_i   (pc_idx),
        .r_off_i   (pc_off),
        .r_valid_o (line_valid),
        .r_tag_o   (line_tag),
        .r_data_o  (instr_out)
    );

    assign hit      = line_valid & (line_tag == pc_tag);
    assign miss_cnt = miss_q;

    // A flush seen mid-fill is remembered and applied in the next IDLE cycle.
    assign stall = (state_q != IDLE)
                 | (fetch_en & ~hit)
                 | ((state_q == IDLE) & (flush | flush_pend_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_tag_q   <= '0;
            fill_idx_q   <= '0;
            issue_q      <= '0;
            ret_q        <= '0;
            miss_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_tag_q   <= fill_tag_d;
            fill_idx_q   <= fill_idx_d;
            issue_q      <= issue_d;
            ret_q        <= ret_d;
            miss_q       <= miss_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_tag_d   = fill_tag_q;
        fill_idx_d   = fill_idx_q;
        issue_d      = issue_q;
        ret_d        = ret_q;
        miss_d       = miss_q;
        flush_pend_d = flush_pend_q;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        arr_flush    = 1'b0;
        arr_inv      = 1'b0;
        arr_fill     = 1'b0;
        arr_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    arr_flush    = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (fetch_en && !hit) begin
                    fill_tag_d = pc_tag;
                    fill_idx_d = pc_idx;
                    arr_inv    = 1'b1;
                    issue_d    = '0;
                    ret_d      = '0;
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                    state_d = FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (issue_q < ISSUE_END) begin
                    mem_rd   = 1'b1;
                    mem_addr = {fill_tag_q, fill_idx_q, issue_q[OFF_W-1:0], 1'b0};
                    issue_d  = issue_q + 1'b1;
                end
                if (mem_rvalid) begin
                    arr_we = 1'b1;
                    ret_d  = ret_q + 1'b1;
                    if (ret_q == RET_LAST) begin
                        arr_fill = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_fill.sv
// Scoreboard bench for icache_fill against a 4-cycle pipelined
// memory whose word at address a is 0x1000 + a[15:1].
module tb_icache_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] pc_addr = '0;
    logic [15:0] instr_out, mem_addr, mem_rdata, miss_cnt;
    logic        stall, mem_rd, mem_rvalid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] ins;
        int          stl;
        logic [15:0] mc;
    } exp_t;

    exp_t sb[$];

    logic [3:0]  pv = '0;
    logic [15:0] pa [4];

    icache_fill #(
        .LINES   (32),
        .WORDS   (8),
        .MEM_LAT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .pc_addr    (pc_addr),
        .flush      (flush),
        .instr_out  (instr_out),
        .stall      (stall),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return 16'h1000 + {1'b0, a[15:1]};
    endfunction

    // Memory is not reset: returns in flight keep arriving after rst_n.
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_rd};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end

    assign mem_rvalid = pv[3];
    assign mem_rdata  = memf(pa[3]);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [15:0] a, input int exp_stl,
                         input logic [15:0] exp_mc, input int flush_at);
        exp_t e;
        int   n;
        pc_addr  = a;
        fetch_en = 1'b1;
        e.ins = memf(a);
        e.stl = exp_stl;
        e.mc  = exp_mc;
        sb.push_back(e);
        n = 0;
        while (1) begin
            flush = (n == flush_at);
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 80) break;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        e = sb.pop_front();
        chk($sformatf("stall_cycles@%h", a), n, e.stl);
        chk($sformatf("instr@%h", a), instr_out, e.ins);
        chk($sformatf("miss_cnt@%h", a), miss_cnt, e.mc);
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [15:0] a, input logic [15:0] exp);
        pc_addr = a;
        #1;
        chk($sformatf("peek_instr@%h", a), instr_out, exp);
        chk($sformatf("peek_stall@%h", a), stall, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_stall_idle", stall, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_miss_cnt", miss_cnt, 16'h0000);
        fetch_en = 1'b1;
        #1;
        chk("rst_stall_fetch", stall, 1'b1);
        fetch_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fetch(16'h0000, 13, 16'd1, -1);
        for (int i = 1; i < 8; i++) begin
            fetch(16'(2 * i), 0, 16'd1, -1);
        end

        fetch(16'h0200, 13, 16'd2, -1);
        fetch(16'h0000, 13, 16'd3, -1);

        // Flush at FILL cycle 3: fill, flush cycle, then a second fill.
        fetch(16'h0010, 27, 16'd5, 4);
        fetch(16'h0012, 0, 16'd5, -1);

        pc_addr  = 16'h0400;
        fetch_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("fill5_mem_rd", mem_rd, 1'b1);
        chk("fill5_mem_addr", mem_addr, 16'h040A);
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        #1;
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_miss_cnt", miss_cnt, 16'h0000);
        chk("midrst_mem_rd", mem_rd, 1'b0);
        chk("midrst_mem_addr", mem_addr, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        peek(16'h0000, 16'h1200);
        peek(16'h0002, 16'h1001);
        peek(16'h0008, 16'h1004);
        chk("post_rst_miss_cnt", miss_cnt, 16'h0000);
        fetch(16'h0400, 13, 16'd1, -1);

        @(negedge clk);
        force dut.miss_q = 16'hFFFE;
        #1;
        release dut.miss_q;
        @(posedge clk);
        #1;
        fetch(16'h0000, 13, 16'hFFFF, -1);
        fetch(16'h0400, 13, 16'hFFFF, -1);
        fetch(16'h0402, 0, 16'hFFFF, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
